// File: rtl/config_chain_loader_if.sv
// Configuration-port bundle between the fabric side and the chain loader.
// The master side is the fabric plus the tile chain; the slave side is the loader.
interface config_chain_loader_if #(
   parameter int unsigned WORD_W = 8
);
   logic              start;
   logic              hard;
   logic [WORD_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic              shift_in_soft;
   logic              shift_in_hard;
   logic              set_soft;
   logic              set_hard;
   logic              shift_out;
   logic [WORD_W-1:0] echo;
   logic              echo_valid;
   logic              busy;
   logic              done;

   modport master (
      output start, hard, din, din_valid, shift_out,
      input  din_ready, shift_in_soft, shift_in_hard, set_soft, set_hard,
             echo, echo_valid, busy, done
   );

   modport slave (
      input  start, hard, din, din_valid, shift_out,
      output din_ready, shift_in_soft, shift_in_hard, set_soft, set_hard,
             echo, echo_valid, busy, done
   );
endinterface

// File: rtl/config_chain_loader.sv
// Buffers one configuration frame, streams it gap-free into the selected
// tile chain, pulses the matching set line, and reassembles the bits that
// fall out of the chain tail into readback words.
module config_chain_loader #(
   parameter int unsigned WORD_W    = 8,
   parameter int unsigned CHAIN_LEN = 14
) (
   input  logic                 clk,
   input  logic                 rst,
   config_chain_loader_if.slave bus
);
   localparam int unsigned NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int unsigned BUF_W  = NWORDS * WORD_W;
   localparam int unsigned WCNT_W = $clog2(NWORDS + 1);
   localparam int unsigned BCNT_W = $clog2(CHAIN_LEN + 1);
   localparam int unsigned LIDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_STREAM,
      S_SET,
      S_DONE
   } state_t;

   state_t              r_state;
   logic                r_hard;
   logic [BUF_W-1:0]    r_buf;
   logic [WCNT_W-1:0]   r_wcnt;
   logic [BCNT_W-1:0]   r_bcnt;
   logic [LIDX_W-1:0]   r_pos;
   logic [WORD_W-1:0]   r_acc;
   logic [WORD_W-1:0]   r_echo;
   logic                r_echo_valid;
   logic                r_din_ready;
   logic                r_sin_soft;
   logic                r_sin_hard;
   logic                r_set_soft;
   logic                r_set_hard;
   logic                r_busy;
   logic                r_done;

   logic [BUF_W-1:0]    w_buf_wr;
   logic [WORD_W-1:0]   w_acc_next;
   logic                w_last_bit;
   logic                w_word_end;

   // Buffer image with the incoming word merged into its slot.
   always_comb begin
      w_buf_wr = r_buf;
      for (int unsigned k = 0; k < NWORDS; k++) begin
         if (r_wcnt == WCNT_W'(k)) begin
            w_buf_wr[k*WORD_W +: WORD_W] = bus.din;
         end
      end
   end

   // Echo accumulator with the current chain-tail bit inserted.
   always_comb begin
      w_acc_next        = r_acc;
      w_acc_next[r_pos] = bus.shift_out;
   end

   assign w_last_bit = (r_bcnt == BCNT_W'(CHAIN_LEN - 1));
   assign w_word_end = (r_pos == LIDX_W'(WORD_W - 1)) || w_last_bit;

   // Load sequencer; every output is a register so reset clears them at once.
   // The buffer doubles as the serialiser: bit 0 is presented on entry to
   // STREAM and the remainder shifts down one place per streamed bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_hard       <= 1'b0;
         r_buf        <= '0;
         r_wcnt       <= '0;
         r_bcnt       <= '0;
         r_pos        <= '0;
         r_acc        <= '0;
         r_echo       <= '0;
         r_echo_valid <= 1'b0;
         r_din_ready  <= 1'b0;
         r_sin_soft   <= 1'b0;
         r_sin_hard   <= 1'b0;
         r_set_soft   <= 1'b0;
         r_set_hard   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_echo_valid <= 1'b0;
         r_echo       <= '0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state     <= S_FILL;
                  r_hard      <= bus.hard;
                  r_wcnt      <= '0;
                  r_bcnt      <= '0;
                  r_din_ready <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            S_FILL: begin
               if (bus.din_valid) begin
                  if (r_wcnt == WCNT_W'(NWORDS - 1)) begin
                     r_state     <= S_STREAM;
                     r_din_ready <= 1'b0;
                     r_buf       <= w_buf_wr >> 1;
                     r_sin_soft  <= ~r_hard & w_buf_wr[0];
                     r_sin_hard  <= r_hard & w_buf_wr[0];
                     r_bcnt      <= '0;
                     r_pos       <= '0;
                     r_acc       <= '0;
                  end else begin
                     r_buf  <= w_buf_wr;
                     r_wcnt <= r_wcnt + 1'b1;
                  end
               end
            end
            S_STREAM: begin
               if (w_word_end) begin
                  r_echo       <= w_acc_next;
                  r_echo_valid <= 1'b1;
                  r_acc        <= '0;
                  r_pos        <= '0;
               end else begin
                  r_acc <= w_acc_next;
                  r_pos <= r_pos + 1'b1;
               end
               if (w_last_bit) begin
                  r_state    <= S_SET;
                  r_sin_soft <= 1'b0;
                  r_sin_hard <= 1'b0;
                  r_set_soft <= ~r_hard;
                  r_set_hard <= r_hard;
               end else begin
                  r_bcnt     <= r_bcnt + 1'b1;
                  r_buf      <= r_buf >> 1;
                  r_sin_soft <= ~r_hard & r_buf[0];
                  r_sin_hard <= r_hard & r_buf[0];
               end
            end
            S_SET: begin
               r_set_soft <= 1'b0;
               r_set_hard <= 1'b0;
               r_done     <= 1'b1;
               r_state    <= S_DONE;
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.din_ready     = r_din_ready;
   assign bus.shift_in_soft = r_sin_soft;
   assign bus.shift_in_hard = r_sin_hard;
   assign bus.set_soft      = r_set_soft;
   assign bus.set_hard      = r_set_hard;
   assign bus.echo          = r_echo;
   assign bus.echo_valid    = r_echo_valid;
   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: directed frame table plus randomized frames.
// Two behavioural chains (soft and hard) hold the last frame loaded into each;
// every cycle of every frame is compared against a timeline derived from them.
module tb_config_chain_loader;
   localparam int unsigned WORD_W    = 8;
   localparam int unsigned CHAIN_LEN = 14;
   localparam int unsigned NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int unsigned BUF_W     = NWORDS * WORD_W;
   localparam int unsigned OW        = WORD_W + 8;

   logic clk = 1'b0;
   logic rst = 1'b0;

   config_chain_loader_if #(.WORD_W(WORD_W)) bus ();

   config_chain_loader #(
      .WORD_W   (WORD_W),
      .CHAIN_LEN(CHAIN_LEN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   logic [CHAIN_LEN-1:0] stored [2];

   typedef struct {
      bit               hard;
      logic [BUF_W-1:0] words;
      int               gap;
      bit               poke;
      int               abort_at;
      bit               chk;
      logic [BUF_W-1:0] echo;
   } vec_t;

   vec_t tbl [7];

   function automatic logic [OW-1:0] exp_vec(logic rdy, logic ss, logic sh, logic ts,
                                             logic th, logic ev, logic [WORD_W-1:0] e,
                                             logic b, logic d);
      return {rdy, ss, sh, ts, th, ev, e, b, d};
   endfunction

   function automatic logic [WORD_W-1:0] frame_word(logic [CHAIN_LEN-1:0] fr, int j);
      logic [WORD_W-1:0] w;
      w = '0;
      for (int b = 0; b < int'(WORD_W); b++) begin
         if (j * int'(WORD_W) + b < int'(CHAIN_LEN)) w[b] = fr[j*int'(WORD_W)+b];
      end
      return w;
   endfunction

   function automatic bit echo_due(int i);
      return ((i % int'(WORD_W)) == int'(WORD_W) - 1) || (i == int'(CHAIN_LEN) - 1);
   endfunction

   task automatic check(input string nm, input logic [OW-1:0] exp);
      logic [OW-1:0] act;
      act = {bus.din_ready, bus.shift_in_soft, bus.shift_in_hard, bus.set_soft,
             bus.set_hard, bus.echo_valid, bus.echo, bus.busy, bus.done};
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s t=%0t: outputs got %h expected %h", nm, $time, act, exp);
   endtask

   task automatic check_word(input string nm, input logic [BUF_W-1:0] act,
                             input logic [BUF_W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: echo words got %h expected %h", nm, act, exp);
   endtask

   task automatic drive_random();
      bus.start     = 1'b0;
      bus.hard      = 1'($urandom);
      bus.din       = WORD_W'($urandom);
      bus.din_valid = 1'($urandom);
      bus.shift_out = 1'($urandom);
   endtask

   // One complete frame from the start cycle through DONE (or an abort by reset).
   task automatic run_frame(input bit h, input logic [BUF_W-1:0] wp, input int gap,
                            input bit poke, input int abort_at,
                            output logic [BUF_W-1:0] eg);
      logic [CHAIN_LEN-1:0] fr, old, mix;
      logic [WORD_W-1:0]    ew;
      bit                   ev;
      bit                   aborted;
      int                   g, lk;
      fr      = wp[CHAIN_LEN-1:0];
      old     = stored[h];
      eg      = '0;
      aborted = 1'b0;

      drive_random();
      bus.start = 1'b1;
      bus.hard  = h;
      @(negedge clk); check("idle_start", '0);
      @(posedge clk); #1;

      for (int k = 0; k < int'(NWORDS); k++) begin
         if (gap < 0) g = int'($urandom_range(0, 2));
         else g = (k == 0) ? 0 : gap;
         for (int c = 0; c <= g; c++) begin
            drive_random();
            bus.start     = 1'($urandom);
            bus.din_valid = (c == g);
            if (c == g) bus.din = wp[k*int'(WORD_W) +: WORD_W];
            @(negedge clk); check("fill", exp_vec(1, 0, 0, 0, 0, 0, '0, 1, 0));
            @(posedge clk); #1;
         end
      end

      for (int i = 0; i < int'(CHAIN_LEN); i++) begin
         drive_random();
         if (poke) begin
            bus.start     = 1'b1;
            bus.din_valid = 1'b1;
         end
         bus.shift_out = old[i];
         ev = (i > 0) && echo_due(i - 1);
         ew = ev ? frame_word(old, (i - 1) / int'(WORD_W)) : '0;
         @(negedge clk);
         check("stream", exp_vec(0, ~h & fr[i], h & fr[i], 0, 0, ev, ew, 1, 0));
         if (ev) eg[((i-1)/int'(WORD_W))*int'(WORD_W) +: WORD_W] = bus.echo;
         if (i == abort_at) begin
            #2 rst = 1'b0;
            #1 check("rst_async", '0);
            @(posedge clk); #1;
            check("rst_hold", '0);
            rst = 1'b1;
            lk  = int'(CHAIN_LEN) - i;
            for (int j = 0; j < int'(CHAIN_LEN); j++) begin
               if (j < lk) mix[j] = old[j+i];
               else mix[j] = fr[j-lk];
            end
            stored[h] = mix;
            aborted   = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end

      if (!aborted) begin
         drive_random();
         if (poke) begin
            bus.start     = 1'b1;
            bus.din_valid = 1'b1;
         end
         ew = frame_word(old, (int'(CHAIN_LEN) - 1) / int'(WORD_W));
         @(negedge clk); check("set", exp_vec(0, 0, 0, ~h, h, 1, ew, 1, 0));
         eg[((CHAIN_LEN-1)/WORD_W)*WORD_W +: WORD_W] = bus.echo;
         @(posedge clk); #1;

         drive_random();
         if (poke) begin
            bus.start     = 1'b1;
            bus.din_valid = 1'b1;
         end
         @(negedge clk); check("done", exp_vec(0, 0, 0, 0, 0, 0, '0, 1, 1));
         @(posedge clk); #1;
         stored[h] = fr;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [BUF_W-1:0] eg;
      logic [BUF_W-1:0] w;

      tbl[0] = '{hard: 0, words: 16'h2DB5, gap: 0, poke: 0, abort_at: -1, chk: 1, echo: 16'h0000};
      tbl[1] = '{hard: 0, words: 16'h3FFF, gap: 0, poke: 0, abort_at: -1, chk: 1, echo: 16'h2DB5};
      tbl[2] = '{hard: 1, words: 16'h155A, gap: 0, poke: 0, abort_at: -1, chk: 1, echo: 16'h0000};
      tbl[3] = '{hard: 1, words: 16'h2A81, gap: 5, poke: 0, abort_at: -1, chk: 1, echo: 16'h155A};
      tbl[4] = '{hard: 0, words: 16'h1133, gap: 0, poke: 1, abort_at: -1, chk: 1, echo: 16'h3FFF};
      tbl[5] = '{hard: 0, words: 16'h3CC3, gap: 0, poke: 0, abort_at: 6,  chk: 0, echo: 16'h0000};
      tbl[6] = '{hard: 0, words: 16'h0000, gap: 0, poke: 0, abort_at: -1, chk: 1, echo: 16'h0344};

      stored[0] = '0;
      stored[1] = '0;

      drive_random();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         drive_random();
         bus.start = 1'($urandom);
         @(negedge clk); check("reset_hold", '0);
         @(posedge clk); #1;
      end
      rst = 1'b1;

      for (int n = 0; n < 7; n++) begin
         run_frame(tbl[n].hard, tbl[n].words, tbl[n].gap, tbl[n].poke, tbl[n].abort_at, eg);
         if (tbl[n].chk) check_word($sformatf("table_echo_%0d", n), eg, tbl[n].echo);
      end

      for (int n = 0; n < 40; n++) begin
         w = BUF_W'({$urandom, $urandom});
         run_frame(1'($urandom), w, -1, 1'($urandom),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, CHAIN_LEN - 1)) : -1,
                   eg);
      end

      drive_random();
      @(negedge clk); check("final_idle", '0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
